// File: rtl/feistel_round_engine.sv
// Iterative Feistel cipher core: one registered round reused NUM_ROUNDS times.
// The round function F lives outside this block; the engine only sequences
// the halves, exposes the subkey index and forwards the subkey to F.
module feistel_round_engine #(
    parameter int HALF_W         = 32,
    parameter int KEY_W          = 48,
    parameter int NUM_ROUNDS     = 16,
    parameter int IDX_W          = 4,
    parameter int UNDO_LAST_SWAP = 1
) (
    input  logic                  wClk,
    input  logic                  wRst,
    input  logic                  wInValid,
    output logic                  wInReady,
    input  logic                  wInDecrypt,
    input  logic [2*HALF_W-1:0]   wInputData,
    output logic [IDX_W-1:0]      oRoundIdx,
    input  logic [KEY_W-1:0]      wSubKey,
    output logic [HALF_W-1:0]     oFIn,
    output logic [KEY_W-1:0]      wFKey,
    input  logic [HALF_W-1:0]     iFOut,
    output logic                  wOutValid,
    input  logic                  wOutReady,
    output logic [2*HALF_W-1:0]   wOutputData,
    output logic                  wBusy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the final round; also the base for the reversed decrypt order.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [HALF_W-1:0]     r_l;
    logic [HALF_W-1:0]     r_r;
    logic [IDX_W-1:0]      r_cnt;
    logic                  r_decrypt;
    logic                  w_accept;
    logic                  w_round;
    logic                  w_last;
    logic [2*HALF_W-1:0]   w_result;

    // State register; reset dominates any handshake in the same cycle.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        wInReady     = 1'b0;
        wOutValid    = 1'b0;
        wBusy        = 1'b0;
        oRoundIdx    = '0;
        w_accept     = 1'b0;
        w_round      = 1'b0;
        w_last       = (r_cnt == LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                wInReady = 1'b1;
                if (wInValid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wBusy     = 1'b1;
                w_round   = 1'b1;
                // Decrypt walks the key schedule backwards; unsigned IDX_W math.
                oRoundIdx = r_decrypt ? (LAST_IDX - r_cnt) : r_cnt;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                wBusy     = 1'b1;
                wOutValid = 1'b1;
                if (wOutReady) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Round datapath: load on accept, then L<=R, R<=L^F(R) once per RUN cycle.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            r_l       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            r_decrypt <= 1'b0;
        end else if (w_accept) begin
            r_l       <= wInputData[2*HALF_W-1 -: HALF_W];
            r_r       <= wInputData[HALF_W-1:0];
            r_decrypt <= wInDecrypt;
            r_cnt     <= '0;
        end else if (w_round) begin
            r_l   <= r_r;
            r_r   <= r_l ^ iFOut;
            r_cnt <= r_cnt + IDX_W'(1);
        end
    end

    // Final half ordering: DES-style ciphers undo the swap of the last round.
    generate
        if (UNDO_LAST_SWAP != 0) begin : g_undo_swap
            assign w_result = {r_r, r_l};
        end else begin : g_keep_swap
            assign w_result = {r_l, r_r};
        end
    endgenerate

    assign oFIn        = r_r;
    assign wFKey       = wSubKey;
    // Result bus is quiet except while a finished block is being offered.
    assign wOutputData = (r_state == ST_DONE) ? w_result : '0;

endmodule

// File: tb/tb_feistel_round_engine.sv
// Bench for feistel_round_engine: DES-configured instance driven with identity
// and real DES round functions, plus a small 8-bit, 3-round instance.
module tb_feistel_round_engine;

    localparam int NR = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_dec, out_valid, out_ready, busy;
    logic [63:0] in_data, out_data;
    logic [3:0]  round_idx;
    logic [47:0] sub_key, f_key;
    logic [31:0] f_in, f_out;
    logic        f_sel;
    logic [47:0] keys [16];

    logic        t_valid, t_ready, t_dec, t_ovalid, t_oready, t_busy;
    logic [15:0] t_data, t_out;
    logic [1:0]  t_idx;
    logic [7:0]  t_key, t_fkey, t_fin, t_fout;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [3:0]  idx_q [$];

    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,
        35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,
        14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,
        30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
        59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,
        30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
        26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,
        34,53,46,42,50,36,29,32};
    localparam int SHIFT_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB_T[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    // DES bit numbering: table entry 1 names the MSB of the in_w-bit source.
    function automatic logic [63:0] permute(input logic [63:0] x, input int in_w,
                                            input int out_w, input int sel);
        logic [63:0] y = '0;
        int src;
        for (int i = 0; i < out_w; i++) begin
            case (sel)
                0: src = IP_T[i[5:0]];
                1: src = FP_T[i[5:0]];
                2: src = E_T[i[5:0]];
                3: src = P_T[i[4:0]];
                4: src = PC1_T[i[5:0]];
                default: src = PC2_T[i[5:0]];
            endcase
            y = (y << 1) | ((x >> (in_w - src)) & 64'd1);
        end
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [5:0]  chunk;
        logic [8:0]  sidx;
        logic [31:0] s = '0;
        e = 48'(permute(64'(r), 32, 48, 2)) ^ k;
        for (int b = 0; b < 8; b++) begin
            chunk = 6'(e >> (42 - 6 * b));
            sidx  = 9'(b * 64 + int'({chunk[5], chunk[0]}) * 16 + int'(chunk[4:1]));
            s     = (s << 4) | 32'(SB_T[sidx]);
        end
        return 32'(permute(64'(s), 32, 32, 3));
    endfunction

    function automatic logic [63:0] ip(input logic [63:0] x);
        return permute(x, 64, 64, 0);
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        return permute(x, 64, 64, 1);
    endfunction

    // Whole-block DES reference: IP, 16 Feistel rounds, swap, FP.
    function automatic logic [63:0] des_block(input logic [63:0] blk, input logic dec);
        logic [63:0] x;
        logic [31:0] l, r, t;
        logic [3:0]  ki;
        x = ip(blk);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            ki = 4'(dec ? 15 - i : i);
            t  = l ^ des_f(r, keys[ki]);
            l  = r;
            r  = t;
        end
        return fp({r, l});
    endfunction

    task automatic gen_keys(input logic [63:0] key);
        logic [55:0] k56;
        logic [27:0] c, d;
        k56 = 56'(permute(key, 64, 56, 4));
        c = k56[55:28];
        d = k56[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFT_T[r[3:0]]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            keys[r[3:0]] = 48'(permute(64'({c, d}), 56, 48, 5));
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    assign sub_key = keys[round_idx];
    assign f_out   = f_sel ? des_f(f_in, f_key) : 32'h0;
    assign t_key   = 8'(t_idx) + 8'd1;
    assign t_fout  = t_fin ^ t_fkey;

    feistel_round_engine u_dut (
        .wClk(clk), .wRst(rst), .wInValid(in_valid), .wInReady(in_ready),
        .wInDecrypt(in_dec), .wInputData(in_data), .oRoundIdx(round_idx),
        .wSubKey(sub_key), .oFIn(f_in), .wFKey(f_key), .iFOut(f_out),
        .wOutValid(out_valid), .wOutReady(out_ready), .wOutputData(out_data),
        .wBusy(busy)
    );

    feistel_round_engine #(.HALF_W(8), .KEY_W(8), .NUM_ROUNDS(3), .IDX_W(2),
                           .UNDO_LAST_SWAP(0)) u_toy (
        .wClk(clk), .wRst(rst), .wInValid(t_valid), .wInReady(t_ready),
        .wInDecrypt(t_dec), .wInputData(t_data), .oRoundIdx(t_idx),
        .wSubKey(t_key), .oFIn(t_fin), .wFKey(t_fkey), .iFOut(t_fout),
        .wOutValid(t_ovalid), .wOutReady(t_oready), .wOutputData(t_out),
        .wBusy(t_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model of the main instance: idle / running round k / holding result.
    // Checked every negedge, then advanced with the inputs that the next edge samples.
    int          m_state = 0;
    int          m_k = 0;
    logic        m_dec = 1'b0;
    logic [31:0] m_l = '0, m_r = '0, m_t;
    logic        m_live = 1'b0;
    logic [3:0]  m_idx;

    always @(negedge clk) begin
        m_idx = (m_state == 1) ? 4'(m_dec ? NR - 1 - m_k : m_k) : 4'd0;
        if (m_live) begin
            check("mdl_in_ready", 64'(in_ready), 64'(m_state == 0));
            check("mdl_out_valid", 64'(out_valid), 64'(m_state == 2));
            check("mdl_busy", 64'(busy), 64'(m_state != 0));
            check("mdl_round_idx", 64'(round_idx), 64'(m_idx));
            check("mdl_f_in", 64'(f_in), 64'(m_r));
            if (m_state == 1) check("mdl_f_key", 64'(f_key), 64'(keys[m_idx]));
            if (m_state == 2) check("mdl_out_data", out_data, {m_r, m_l});
        end
        if (rst) begin
            m_live = 1'b1; m_state = 0; m_k = 0; m_dec = 1'b0; m_l = '0; m_r = '0;
        end else if (m_state == 0) begin
            if (in_valid) begin
                m_l = in_data[63:32]; m_r = in_data[31:0];
                m_dec = in_dec; m_k = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            m_t = m_l ^ (f_sel ? des_f(m_r, keys[m_idx]) : 32'h0);
            m_l = m_r;
            m_r = m_t;
            if (m_k == NR - 1) m_state = 2;
            else m_k = m_k + 1;
        end else if (out_ready) begin
            m_state = 0;
        end
    end

    task automatic send(input logic [63:0] d, input logic dec);
        int n = 0;
        @(posedge clk); #2;
        in_valid = 1'b1; in_data = d; in_dec = dec;
        do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 40);
        if (in_ready !== 1'b1) timeout("accept_wait");
        @(posedge clk); #2;
        in_valid = 1'b0; in_data = ~d; in_dec = ~dec;
    endtask

    // Latency counted in negedges from the accept cycle's negedge.
    task automatic wait_result(output logic [63:0] res, output int lat);
        idx_q.delete();
        lat = 0;
        res = '0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) begin
                res = out_data;
                return;
            end
            if (busy === 1'b1) idx_q.push_back(round_idx);
        end
        timeout("result_wait");
    endtask

    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    initial begin
        logic [63:0] res, res0;
        logic [63:0] pts [3];
        int          lat, n;
        int          acc [3];
        pts[0] = PT; pts[1] = 64'hFEDCBA9876543210; pts[2] = 64'h0000000000000001;
        rst = 1'b1; in_valid = 1'b0; in_dec = 1'b0; in_data = '0; out_ready = 1'b1;
        f_sel = 1'b0; t_valid = 1'b0; t_dec = 1'b0; t_data = '0; t_oready = 1'b1;
        gen_keys(64'h133457799BBCDFF1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        check("rst_out_data", out_data, 64'd0);

        // Identity F: 16 swaps cancel, last-swap undo yields R0||L0.
        send(PT, 1'b0);
        wait_result(res, lat);
        check("id_latency", 64'(lat), 64'd17);
        check("id_result", res, 64'h89ABCDEF01234567);
        check("id_idx_count", 64'(idx_q.size()), 64'd16);
        foreach (idx_q[i]) check("id_idx_seq", 64'(idx_q[i]), 64'(i));

        // DES known-answer, encrypt then decrypt.
        f_sel = 1'b1;
        send(ip(PT), 1'b0);
        wait_result(res, lat);
        check("des_enc", fp(res), CT);
        check("des_enc_latency", 64'(lat), 64'd17);
        send(ip(CT), 1'b1);
        wait_result(res, lat);
        check("des_dec", fp(res), PT);
        check("des_dec_idx_count", 64'(idx_q.size()), 64'd16);
        foreach (idx_q[i]) check("des_dec_idx_seq", 64'(idx_q[i]), 64'(15 - i));

        // Output backpressure with stray input pulses.
        @(posedge clk); #2 out_ready = 1'b0;
        send(ip(pts[1]), 1'b0);
        wait_result(res0, lat);
        check("bp_result", fp(res0), des_block(pts[1], 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            in_valid = ~in_valid; in_data = 64'($urandom) << 32 | 64'($urandom);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_data_stable", out_data, res0);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #2 in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_after_valid", 64'(out_valid), 64'd0);
        check("bp_after_in_ready", 64'(in_ready), 64'd1);

        // Reset while round counter is 7.
        send(ip(PT), 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy === 1'b1 && round_idx == 4'd6) && n < 40);
        if (n >= 40) timeout("idx6_wait");
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_idx", 64'(round_idx), 64'd0);

        // Reset and valid together: the block must not be taken.
        @(posedge clk); #2 rst = 1'b1; in_valid = 1'b1; in_data = ip(pts[2]);
        @(posedge clk); #2 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_busy", 64'(busy), 64'd0);
        send(ip(PT), 1'b0);
        wait_result(res, lat);
        check("post_rst_enc", fp(res), CT);

        // Back-to-back with valid held high.
        @(posedge clk); #2 in_valid = 1'b1; in_data = ip(pts[0]); in_dec = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 40);
            if (n >= 40) timeout("b2b_accept");
            acc[b] = cyc;
            @(posedge clk); #2;
            if (b < 2) in_data = ip(pts[b + 1]);
            else in_valid = 1'b0;
            wait_result(res, lat);
            check("b2b_latency", 64'(lat), 64'd17);
            check("b2b_result", fp(res), des_block(pts[b], 1'b0));
        end
        check("b2b_spacing_01", 64'(acc[1] - acc[0]), 64'd18);
        check("b2b_spacing_12", 64'(acc[2] - acc[1]), 64'd18);
        check("model_pin_ct", des_block(PT, 1'b0), CT);

        // Small 3-round instance with F = R ^ (idx+1), no last-swap undo.
        @(posedge clk); #2 t_valid = 1'b1; t_data = 16'h1234;
        @(negedge clk);
        check("toy_in_ready", 64'(t_ready), 64'd1);
        @(posedge clk); #2 t_valid = 1'b0; t_data = 16'hFFFF;
        idx_q.delete();
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (t_ovalid === 1'b1) break;
            if (t_busy === 1'b1) idx_q.push_back(4'(t_idx));
        end
        if (t_ovalid !== 1'b1) timeout("toy_result");
        check("toy_latency", 64'(lat), 64'd4);
        check("toy_result", 64'(t_out), 64'h1135);
        check("toy_idx_count", 64'(idx_q.size()), 64'd3);
        foreach (idx_q[i]) check("toy_idx_seq", 64'(idx_q[i]), 64'(i));
        @(negedge clk);
        check("toy_idle", 64'(t_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
